// File: rtl/i2c_spi_bridge_ctrl.sv
// i2c_spi_bridge_ctrl: forwards bytes received by the I2C slave to an SPI
// master port and queues the simultaneously received MISO bytes in a
// response FIFO that feeds the slave's read path. spi_cs_n spans one I2C
// transaction, delimited by i2c_busy.
// Optional build macro SPI_MODE3_EN: CPOL=1/CPHA=1 (sclk idles high, mosi
// changes on the falling edge). Without it the port runs in SPI mode 0.
module i2c_spi_bridge_ctrl #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       i2c_busy,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_cs_n,
    output logic       overflow,
    output logic       ctrl_busy
);

    localparam int             AW       = $clog2(FIFO_DEPTH);
    localparam logic [7:0]     DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [AW:0]    FULL_CNT = FIFO_DEPTH[AW:0];
`ifdef SPI_MODE3_EN
    localparam logic           SCLK_IDLE = 1'b1;
`else
    localparam logic           SCLK_IDLE = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        DONE  = 3'd3,
        GAP   = 3'd4,
        HOLD  = 3'd5
    } state_t;

    state_t         state;
    state_t         state_d;
    logic           load_sh;
    logic           push;

    logic [7:0]     div_cnt;
    logic           div_done;
    logic           ph;
    logic [2:0]     bit_cnt;
    logic           sclk_edge;
    logic           sclk_rise;
    logic           sclk_fall;

    logic           hold_full;
    logic [7:0]     hold_data;
    logic [7:0]     tx_shift;
    logic [7:0]     rx_shift;

    logic           busy_p1;
    logic           start_txn;

    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           fifo_empty;
    logic           fifo_full;
    logic           pop;
    logic           push_ok;
    logic           drop_resp;
    logic           drop_in;

    assign div_done   = (div_cnt == DIV_LAST);
    assign sclk_edge  = (state == SHIFT) && div_done;
    // Both modes sample MISO when sclk goes low->high and move MOSI when it
    // goes high->low; only the idle level and the first-half level differ.
    assign sclk_rise  = sclk_edge && !spi_sclk;
    assign sclk_fall  = sclk_edge && spi_sclk;

    assign start_txn  = i2c_busy && !busy_p1 && (state == IDLE);

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign pop        = tx_ready && !fifo_empty;
    assign push_ok    = push && (!fifo_full || pop);
    assign drop_resp  = push && fifo_full && !pop;
    assign drop_in    = rx_valid && hold_full;

    assign tx_valid   = !fifo_empty;
    assign tx_data    = fifo_empty ? 8'hFF : mem[rd_ptr];
    assign ctrl_busy  = (state != IDLE);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // FSM next-state and per-cycle control strobes
    always_comb begin
        state_d = state;
        load_sh = 1'b0;
        push    = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full) state_d = SETUP;
            end
            SETUP: begin
                if (div_done) begin
                    state_d = SHIFT;
                    load_sh = 1'b1;
                end
            end
            SHIFT: begin
                if (div_done && ph && (bit_cnt == 3'd7)) state_d = DONE;
            end
            DONE: begin
                push = 1'b1;
                if (hold_full) begin
                    state_d = SHIFT;
                    load_sh = 1'b1;
                end else begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (hold_full) begin
                    state_d = SHIFT;
                    load_sh = 1'b1;
                end else if (!i2c_busy) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (div_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Half-period divider, half-bit phase and bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            ph      <= 1'b0;
            bit_cnt <= '0;
        end else begin
            if ((state_d != state) || div_done) div_cnt <= '0;
            else                                div_cnt <= div_cnt + 8'd1;
            if (load_sh) begin
                ph      <= 1'b0;
                bit_cnt <= '0;
            end else if (sclk_edge) begin
                ph <= ~ph;
                if (ph) bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // SPI pins: cs_n follows the next state, sclk toggles each half-bit
    always_ff @(posedge clk) begin
        if (rst) begin
            spi_cs_n <= 1'b1;
            spi_sclk <= SCLK_IDLE;
            spi_mosi <= 1'b0;
        end else begin
            spi_cs_n <= (state_d == IDLE);
            if (state_d != SHIFT) spi_sclk <= SCLK_IDLE;
            else if (sclk_edge)   spi_sclk <= ~spi_sclk;
`ifdef SPI_MODE3_EN
            if (sclk_fall) spi_mosi <= tx_shift[7];
`else
            if (load_sh)        spi_mosi <= hold_data[7];
            else if (sclk_fall) spi_mosi <= tx_shift[6];
`endif
        end
    end

    // Transmit and receive shifters
    always_ff @(posedge clk) begin
        if (load_sh)        tx_shift <= hold_data;
        else if (sclk_fall) tx_shift <= {tx_shift[6:0], 1'b0};
        if (sclk_rise)      rx_shift <= {rx_shift[6:0], spi_miso};
    end

    // One-byte holding register between the I2C slave and the shifter
    always_ff @(posedge clk) begin
        if (rst)                         hold_full <= 1'b0;
        else if (rx_valid && !hold_full) hold_full <= 1'b1;
        else if (load_sh)                hold_full <= 1'b0;
        if (rx_valid && !hold_full) hold_data <= rx_data;
    end

    // Registered copy of i2c_busy for START edge detection
    always_ff @(posedge clk) begin
        if (rst) busy_p1 <= 1'b0;
        else     busy_p1 <= i2c_busy;
    end

    // Response FIFO pointers and occupancy; flushed at transaction start
    always_ff @(posedge clk) begin
        if (rst || start_txn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Response FIFO storage
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= rx_shift;
    end

    // Sticky drop flag, cleared when a new transaction starts
    always_ff @(posedge clk) begin
        if (rst)                       overflow <= 1'b0;
        else if (drop_in || drop_resp) overflow <= 1'b1;
        else if (start_txn)            overflow <= 1'b0;
    end

endmodule

// File: tb/tb_i2c_spi_bridge_ctrl.sv
// tb_i2c_spi_bridge_ctrl: directed bench for i2c_spi_bridge_ctrl with
// CLK_DIV=2, FIFO_DEPTH=4 and MISO looped back from MOSI, so every response
// byte equals the byte shifted out.
module tb_i2c_spi_bridge_ctrl;

    localparam int CLK_DIV    = 2;
    localparam int FIFO_DEPTH = 4;
`ifdef SPI_MODE3_EN
    localparam logic SCLK_IDLE = 1'b1;
`else
    localparam logic SCLK_IDLE = 1'b0;
`endif

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] rx_data  = 8'h00;
    logic       rx_valid = 1'b0;
    logic       i2c_busy = 1'b0;
    logic       tx_ready = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_cs_n;
    logic       overflow;
    logic       ctrl_busy;

    int checks = 0;
    int passed = 0;

    assign spi_miso = spi_mosi;

    i2c_spi_bridge_ctrl #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .i2c_busy  (i2c_busy),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .spi_cs_n  (spi_cs_n),
        .overflow  (overflow),
        .ctrl_busy (ctrl_busy)
    );

    always #5 clk = ~clk;

    // SPI line monitor: logs MOSI at each sclk rise, rise spacing, high time
    int          cyc           = 0;
    int          rise_cnt      = 0;
    int          cs_rise_cnt   = 0;
    int          last_iv       = 0;
    int          last_rise_cyc = 0;
    int          hi_run        = 0;
    int          last_hi       = 0;
    logic [63:0] mosi_log      = '0;
    logic        sclk_q        = SCLK_IDLE;
    logic        cs_q          = 1'b1;

    always @(negedge clk) begin
        cyc    <= cyc + 1;
        sclk_q <= spi_sclk;
        cs_q   <= spi_cs_n;
        if (spi_sclk === 1'b1 && sclk_q === 1'b0) begin
            mosi_log      <= {mosi_log[62:0], spi_mosi};
            rise_cnt      <= rise_cnt + 1;
            last_iv       <= cyc - last_rise_cyc;
            last_rise_cyc <= cyc;
        end
        if (spi_cs_n === 1'b1 && cs_q === 1'b0) cs_rise_cnt <= cs_rise_cnt + 1;
        if (spi_sclk === 1'b1) begin
            hi_run <= hi_run + 1;
        end else begin
            if (sclk_q === 1'b1) last_hi <= hi_run;
            hi_run <= 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_rx(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pop_once();
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
    endtask

    task automatic wait_rises(input int n);
        int k = 0;
        while (rise_cnt < n && k < 400) begin
            tick();
            k++;
        end
        chk("rise_wait", 64'(rise_cnt >= n), 64'd1);
    endtask

    task automatic send(input logic [7:0] b);
        int base = rise_cnt;
        pulse_rx(b);
        wait_rises(base + 8);
        repeat (6) tick();
    endtask

    task automatic end_txn();
        int k = 0;
        i2c_busy = 1'b0;
        while (ctrl_busy && k < 100) begin
            tick();
            k++;
        end
        chk("idle_wait", 64'(ctrl_busy), 64'd0);
    endtask

    int b0;
    int cr;

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_cs_n",     64'(spi_cs_n),  64'd1);
        chk("rst_sclk",     64'(spi_sclk),  64'(SCLK_IDLE));
        chk("rst_mosi",     64'(spi_mosi),  64'd0);
        chk("rst_tx_valid", 64'(tx_valid),  64'd0);
        chk("rst_tx_data",  64'(tx_data),   64'hFF);
        chk("rst_overflow", 64'(overflow),  64'd0);
        chk("rst_busy",     64'(ctrl_busy), 64'd0);
        rst = 1'b0;
        tick();

        // Single write of A5
        i2c_busy = 1'b1;
        tick();
        b0 = rise_cnt;
        pulse_rx(8'hA5);
        tick();
        chk("t1_cs_low",    64'(spi_cs_n),  64'd0);
        chk("t1_ctrl_busy", 64'(ctrl_busy), 64'd1);
        wait_rises(b0 + 8);
        chk("t1_mosi_bits", 64'(mosi_log[7:0]), 64'hA5);
        chk("t1_rise_iv",   64'(last_iv),       64'd4);
        repeat (6) tick();
        chk("t1_hi_len",    64'(last_hi),  64'd2);
        chk("t1_tx_valid",  64'(tx_valid), 64'd1);
        chk("t1_tx_data",   64'(tx_data),  64'hA5);
        chk("t1_cs_gap",    64'(spi_cs_n), 64'd0);
        i2c_busy = 1'b0;
        tick();
        tick();
        chk("t1_cs_hold",   64'(spi_cs_n), 64'd0);
        tick();
        chk("t1_cs_rise",   64'(spi_cs_n),  64'd1);
        chk("t1_idle",      64'(ctrl_busy), 64'd0);

        // New transaction flushes, then back-to-back 12,34 with a dropped 77
        i2c_busy = 1'b1;
        tick();
        chk("t2_flush_valid", 64'(tx_valid), 64'd0);
        chk("t2_flush_data",  64'(tx_data),  64'hFF);
        cr = cs_rise_cnt;
        b0 = rise_cnt;
        pulse_rx(8'h12);
        wait_rises(b0 + 2);
        pulse_rx(8'h34);
        pulse_rx(8'h77);
        chk("t2_in_overflow", 64'(overflow), 64'd1);
        wait_rises(b0 + 9);
        chk("t2_no_setup_iv", 64'(last_iv), 64'd5);
        wait_rises(b0 + 16);
        chk("t2_mosi_bits",   64'(mosi_log[15:0]), 64'h1234);
        repeat (6) tick();
        chk("t2_cs_held",     64'(cs_rise_cnt), 64'(cr));
        chk("t2_no_3rd_byte", 64'(rise_cnt),    64'(b0 + 16));
        chk("t2_head0",       64'(tx_data),  64'h12);
        pop_once();
        chk("t2_head1",       64'(tx_data),  64'h34);
        chk("t2_valid1",      64'(tx_valid), 64'd1);
        pop_once();
        chk("t2_empty_valid", 64'(tx_valid), 64'd0);
        chk("t2_empty_data",  64'(tx_data),  64'hFF);
        pop_once();
        chk("t2_pop_empty",   64'(tx_data),  64'hFF);
        chk("t2_pop_empty_v", 64'(tx_valid), 64'd0);
        end_txn();
        i2c_busy = 1'b1;
        tick();
        chk("t2_ovf_cleared", 64'(overflow), 64'd0);

        // Response overflow: five bytes, no pops
        send(8'h3C);
        send(8'hC3);
        send(8'h5A);
        send(8'h96);
        chk("t3_ovf_4",    64'(overflow), 64'd0);
        chk("t3_valid_4",  64'(tx_valid), 64'd1);
        send(8'h0F);
        chk("t3_ovf_5",    64'(overflow), 64'd1);
        chk("t3_head0",    64'(tx_data), 64'h3C);
        pop_once();
        chk("t3_head1",    64'(tx_data), 64'hC3);
        pop_once();
        chk("t3_head2",    64'(tx_data), 64'h5A);
        pop_once();
        chk("t3_head3",    64'(tx_data), 64'h96);
        pop_once();
        chk("t3_drained",  64'(tx_valid), 64'd0);
        chk("t3_drained_d", 64'(tx_data), 64'hFF);

        // New transaction with FIFO non-empty and overflow set
        send(8'hE7);
        chk("t4_pre_data",  64'(tx_data), 64'hE7);
        end_txn();
        chk("t4_pre_valid", 64'(tx_valid), 64'd1);
        chk("t4_pre_ovf",   64'(overflow), 64'd1);
        i2c_busy = 1'b1;
        tick();
        chk("t4_valid",     64'(tx_valid), 64'd0);
        chk("t4_ovf",       64'(overflow), 64'd0);

        // Reset in the middle of a byte
        send(8'h81);
        chk("t5_pre_valid", 64'(tx_valid), 64'd1);
        b0 = rise_cnt;
        pulse_rx(8'h42);
        wait_rises(b0 + 3);
        tick();
        rst = 1'b1;
        tick();
        chk("t5_cs_n",     64'(spi_cs_n),  64'd1);
        chk("t5_sclk",     64'(spi_sclk),  64'(SCLK_IDLE));
        chk("t5_mosi",     64'(spi_mosi),  64'd0);
        chk("t5_tx_valid", 64'(tx_valid),  64'd0);
        chk("t5_busy",     64'(ctrl_busy), 64'd0);
        rst = 1'b0;
        repeat (40) tick();
        chk("t5_no_push",  64'(tx_valid),  64'd0);
        chk("t5_no_rises", 64'(rise_cnt),  64'(b0 + 3));
        chk("t5_cs_still", 64'(spi_cs_n),  64'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
